// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks every WIDTH-bit vector through an inverter bank,
// waits SETTLE cycles per vector, then compares the bank output against the
// bitwise complement of the stimulus. It reports a saturating mismatch count,
// the first failing vector and a pass flag at the end of the sweep.
module gate_sweep_ctrl #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] gut_out,
  output logic [WIDTH-1:0] gut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] first_fail
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Last settle count before moving on to the compare cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  logic       mismatch;
  logic [7:0] err_inc;
  logic [7:0] err_after;

  // Case-equality makes any X/Z bit on the bank output count as a mismatch;
  // the increment saturates at 255.
  always_comb begin
    mismatch  = (gut_out === ~gut_in) ? 1'b0 : 1'b1;
    err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    err_after = mismatch ? err_inc : err_count;
  end

  // Sweep sequencer: all outputs are registered and updated on state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gut_in     <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            gut_in     <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            first_fail <= '0;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            if (mismatch) begin
              err_count <= err_inc;
              if (err_count == 8'd0) begin
                first_fail <= gut_in;
              end
            end
            if (gut_in != {WIDTH{1'b1}}) begin
              gut_in     <= gut_in + 1'b1;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else begin
              // The result and done pulse appear together in the FINISH cycle.
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_after == 8'd0);
              state <= ST_FINISH;
            end
          end
        end

        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the gate-under-test (GUT) bus; legal range 1..8.
REQ-002 SHALL have parameter SETTLE, default 2: cycles each vector is held before sampling; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a sweep when sampled high in IDLE.
REQ-006 SHALL have port abort  input  1  ends a sweep early and returns to IDLE.
REQ-007 SHALL have port gut_out  input  WIDTH  output of the inverter bank under test.
REQ-008 SHALL have port gut_in  output  WIDTH  registered stimulus driven to the GUT.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  output  1  result of the last completed sweep.
REQ-012 SHALL have port err_count  output  8  saturating mismatch count.
REQ-013 SHALL have port first_fail  output  WIDTH  first vector that mismatched.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, CHECK and FINISH.
REQ-015 IDLE with start=1 SHALL set gut_in=0, settle_cnt=0, err_count=0 and first_fail=0, raise busy and go to SETTLE.
REQ-016 SETTLE SHALL hold gut_in, increment settle_cnt each cycle, and go to CHECK on the edge where settle_cnt==SETTLE-1; exactly SETTLE cycles are spent per vector.
REQ-017 CHECK SHALL last one cycle and compare gut_out against ~gut_in bitwise; any unequal bit, including X/Z, SHALL count as a mismatch.
REQ-018 On a mismatch, err_count SHALL increment and saturate at 255.
REQ-019 On a mismatch with err_count==0 before the increment, first_fail SHALL capture gut_in.
REQ-020 CHECK with gut_in != all-ones SHALL increment gut_in, clear settle_cnt and go to SETTLE.
REQ-021 CHECK with gut_in == all-ones SHALL go to FINISH, sweeping 2^WIDTH vectors in ascending order.
REQ-022 FINISH SHALL assert done for exactly one cycle, set pass=(err_count==0), clear busy and go to IDLE.
REQ-023 done SHALL be high in the cycle after the 2^WIDTH*(SETTLE+1)-th rising edge counted from the start-sampling edge (48 at the default parameters).
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 abort=1 in SETTLE or CHECK SHALL go to IDLE on the next edge with busy=0, no done pulse, and pass, err_count and first_fail frozen.
REQ-026 abort SHALL take priority over a CHECK-cycle mismatch update.
REQ-027 abort SHALL have no effect in IDLE or FINISH.
REQ-028 pass, err_count and first_fail SHALL hold their values until the next accepted start.
REQ-029 gut_in SHALL hold its last value while in IDLE.

Reset
REQ-030 rst high SHALL immediately force state=IDLE, gut_in=0, settle_cnt=0, busy=0, done=0, pass=0, err_count=0 and first_fail=0.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep without a done pulse.
REQ-032 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-033 The bench SHALL cover: gut_out = ~gut_in (ideal inverter), start pulse -> done at edge 48, pass=1, err_count=0, gut_in visits 0..15 in order.
REQ-034 The bench SHALL cover: gut_out[0] stuck at 0 -> pass=0, err_count=8, first_fail=4'h0.
REQ-035 The bench SHALL cover: gut_out = 4'bxxxx for vector 5 only -> err_count=1, first_fail=4'h5, pass=0.
REQ-036 The bench SHALL cover: start re-pulsed at cycles 10 and 20 of a sweep -> ignored, done still at edge 48 with a single pulse.
REQ-037 The bench SHALL cover: abort at cycle 7 -> busy=0 on the next edge, no done, err_count unchanged; a following start -> full sweep passes.
REQ-038 The bench SHALL cover: rst pulsed mid-SETTLE -> all outputs 0 immediately (asynchronous), no done; start on the first edge after release -> normal sweep.
